// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched: round-robin fetch scheduler for the 4-thread barrel
// pipeline. Keeps one PC per hardware thread and issues the next enabled
// thread after the last one issued. Applies branch/jump redirects and holds
// issue under a global stall from the hazard logic.
module thread_fetch_sched #(
  parameter int unsigned PROC_ADDR_WIDTH = 9
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [3:0]                 thread_en,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [1:0]                 redirect_thread,
  input  logic [PROC_ADDR_WIDTH-1:0] redirect_pc,
  output logic [PROC_ADDR_WIDTH-1:0] imem_addr,
  output logic [1:0]                 thread_id_out,
  output logic                       fetch_valid
);

  logic [PROC_ADDR_WIDTH-1:0] pc [4];
  logic [1:0]                 last_tid;
  logic [1:0]                 sel;
  logic                       sel_found;
  logic [1:0]                 cand;
  logic                       issue;
  logic [PROC_ADDR_WIDTH-1:0] pc_sel_next;

  // Pick the first enabled thread after last_tid, wrapping around to last_tid itself
  always_comb begin
    sel       = last_tid;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_tid + i[1:0];
      if (!sel_found && thread_en[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  // Issue qualification and the selected thread's incremented PC
  always_comb begin
    issue       = !stall && sel_found;
    pc_sel_next = pc[sel] + PROC_ADDR_WIDTH'(1);
  end

  // Per-thread PCs; the redirect is written last so it overrides the increment
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int unsigned t = 0; t < 4; t++) begin
        pc[t] <= PROC_ADDR_WIDTH'(t) << (PROC_ADDR_WIDTH - 2);
      end
    end else begin
      if (issue) begin
        pc[sel] <= pc_sel_next;
      end
      if (redirect_valid) begin
        pc[redirect_thread] <= redirect_pc;
      end
    end
  end

  // Round-robin pointer and the registered fetch presented to the IF stage
  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_tid      <= 2'd3;
      imem_addr     <= '0;
      thread_id_out <= '0;
      fetch_valid   <= 1'b0;
    end else if (!stall) begin
      if (sel_found) begin
        last_tid      <= sel;
        imem_addr     <= pc[sel];
        thread_id_out <= sel;
        fetch_valid   <= 1'b1;
      end else begin
        fetch_valid   <= 1'b0;
      end
    end
  end

endmodule
